// File: rtl/lcd_refresh_scheduler.sv
// lcd_refresh_scheduler: snapshots the game table and paces LCD frame refreshes
// with update coalescing, a post-frame hold-off and a stalled-frame timeout.
module lcd_refresh_scheduler #(
    parameter int TABLE_W = 100,
    parameter int MIN_GAP = 1000,
    parameter int GAP_W   = 16,
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TABLE_W-1:0] game_table,
    input  logic               table_upd,
    input  logic               force_refresh,
    input  logic               frame_done,
    output logic               frame_start,
    output logic [TABLE_W-1:0] snap_table,
    output logic               busy,
    output logic               pending,
    output logic [7:0]         frame_cnt,
    output logic               timeout_err
);
    localparam logic [2:0] IDLE = 3'd0, SNAP = 3'd1, START = 3'd2, WAIT_DONE = 3'd3, HOLDOFF = 3'd4;
    logic [2:0]       state, state_nx;
    logic [GAP_W-1:0] gap;
    logic [TO_W-1:0]  to_cnt;
    logic             req, upd, to_hit, gap_hit;
    assign upd         = table_upd | force_refresh;
    assign req         = pending | upd;
    assign to_hit      = to_cnt == TO_W'(TIMEOUT - 1);
    assign gap_hit     = gap == GAP_W'(MIN_GAP - 1);
    assign frame_start = state == START;
    assign busy        = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = req ? SNAP : IDLE;
            SNAP:      state_nx = START;
            START:     state_nx = WAIT_DONE;
            WAIT_DONE: state_nx = (frame_done || to_hit) ? HOLDOFF : WAIT_DONE;
            HOLDOFF:   state_nx = (force_refresh || gap_hit) ? IDLE : HOLDOFF;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b1;
            snap_table  <= '0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
            gap         <= '0;
            to_cnt      <= '0;
        end else begin
            state   <= state_nx;
            // a strobe in the SNAP cycle itself must survive to request the next frame
            pending <= upd ? 1'b1 : (state == SNAP) ? 1'b0 : pending;
            to_cnt  <= (state == WAIT_DONE) ? to_cnt + 1'b1 : '0;
            gap     <= (state == HOLDOFF) ? gap + 1'b1 : '0;
            if (state == SNAP)
                snap_table <= game_table;
            if (state == WAIT_DONE && frame_done)
                frame_cnt <= frame_cnt + 8'd1;
            else if (state == WAIT_DONE && to_hit)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// tb_lcd_refresh_scheduler: vector table, directed corner sequences and random
// stimulus checked against a countdown-based behavioural model.
module tb_lcd_refresh_scheduler;
    localparam int TW = 100, MG = 4, TO = 20;
    localparam int CW = TW + 12;
    logic          clk = 0, rst = 1, table_upd = 0, force_refresh = 0, frame_done = 0;
    logic [TW-1:0] game_table = '0;
    logic          frame_start, busy, pending, timeout_err;
    logic [TW-1:0] snap_table;
    logic [7:0]    frame_cnt;
    int            passed = 0, total = 0;
    int            m_ph, m_left, m_cnt;
    bit            m_pend, m_err;
    logic [TW-1:0] m_snap;

    typedef struct {
        bit r, u, f, d;
        logic [TW-1:0] g;
        bit fs, bsy, pnd;
        logic [7:0] cnt;
        bit err;
        logic [TW-1:0] snap;
    } vec_t;
    vec_t tv[14];

    always #5 clk = ~clk;

    lcd_refresh_scheduler #(.TABLE_W(TW), .MIN_GAP(MG), .GAP_W(8), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .game_table(game_table), .table_upd(table_upd),
        .force_refresh(force_refresh), .frame_done(frame_done), .frame_start(frame_start),
        .snap_table(snap_table), .busy(busy), .pending(pending), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err)
    );

    task automatic chk(string name, logic [CW-1:0] got, logic [CW-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // phases: 0 idle, 1 snapshot, 2 start, 3 awaiting done, 4 hold-off; m_left counts down
    task automatic model_step(bit r, bit u, bit f, bit d, logic [TW-1:0] g);
        int nph;
        if (r) begin
            m_ph = 0; m_pend = 1; m_snap = '0; m_cnt = 0; m_err = 0;
            return;
        end
        nph = m_ph;
        case (m_ph)
            0: if (m_pend || u || f) nph = 1;
            1: begin m_snap = g; nph = 2; end
            2: begin nph = 3; m_left = TO; end
            3: if (d) begin
                m_cnt = (m_cnt + 1) % 256; nph = 4; m_left = MG;
            end else begin
                m_left--;
                if (m_left == 0) begin m_err = 1; nph = 4; m_left = MG; end
            end
            default: begin m_left--; if (f || m_left == 0) nph = 0; end
        endcase
        if (u || f) m_pend = 1;
        else if (m_ph == 1) m_pend = 0;
        m_ph = nph;
    endtask

    function automatic logic [CW-1:0] pack(bit fs, bit b, bit p, logic [7:0] c, bit e, logic [TW-1:0] s);
        return {fs, b, p, c, e, s};
    endfunction

    task automatic cyc(bit r, bit u, bit f, bit d, logic [TW-1:0] g);
        rst = r; table_upd = u; force_refresh = f; frame_done = d; game_table = g;
        @(posedge clk);
        model_step(r, u, f, d, g);
        #1;
        chk("cycle", pack(frame_start, busy, pending, frame_cnt, timeout_err, snap_table),
            pack(m_ph == 2, m_ph != 0, m_pend, 8'(m_cnt), m_err, m_snap));
    endtask

    task automatic idle(int n, logic [TW-1:0] g);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, g);
    endtask

    initial begin
        logic [TW-1:0] ga, gb, gc, rg;
        int n;
        ga = {4{25'h0AAAAAA}}; gb = {4{25'h1555555}}; gc = 100'hC0FFEE_0000_1234;
        tv[0]  = '{1,0,0,0,TW'(5), 0,0,1,8'd0,0,TW'(0)};
        tv[1]  = '{1,0,0,0,TW'(5), 0,0,1,8'd0,0,TW'(0)};
        tv[2]  = '{1,0,0,0,TW'(5), 0,0,1,8'd0,0,TW'(0)};
        tv[3]  = '{0,0,0,0,TW'(5), 0,1,1,8'd0,0,TW'(0)};
        tv[4]  = '{0,0,0,0,TW'(5), 1,1,0,8'd0,0,TW'(5)};
        tv[5]  = '{0,0,0,0,TW'(5), 0,1,0,8'd0,0,TW'(5)};
        tv[6]  = '{0,0,0,1,TW'(5), 0,1,0,8'd1,0,TW'(5)};
        tv[7]  = '{0,0,0,0,TW'(5), 0,1,0,8'd1,0,TW'(5)};
        tv[8]  = '{0,0,0,0,TW'(5), 0,1,0,8'd1,0,TW'(5)};
        tv[9]  = '{0,0,0,0,TW'(5), 0,1,0,8'd1,0,TW'(5)};
        tv[10] = '{0,0,0,0,TW'(5), 0,0,0,8'd1,0,TW'(5)};
        tv[11] = '{0,0,0,0,TW'(5), 0,0,0,8'd1,0,TW'(5)};
        tv[12] = '{0,1,0,0,TW'(7), 0,1,1,8'd1,0,TW'(5)};
        tv[13] = '{0,0,0,0,TW'(9), 1,1,0,8'd1,0,TW'(9)};
        for (int i = 0; i < 14; i++) begin
            cyc(tv[i].r, tv[i].u, tv[i].f, tv[i].d, tv[i].g);
            chk($sformatf("table[%0d]", i), pack(frame_start, busy, pending, frame_cnt, timeout_err, snap_table),
                pack(tv[i].fs, tv[i].bsy, tv[i].pnd, tv[i].cnt, tv[i].err, tv[i].snap));
        end
        // coalescing: three updates during one frame yield one more frame with the last table
        idle(1, TW'(9));
        cyc(0, 1, 0, 0, ga); cyc(0, 1, 0, 0, gb); cyc(0, 1, 0, 0, gc);
        idle(2, gc);
        cyc(0, 0, 0, 1, gc);
        chk("coalesce_cnt", CW'(frame_cnt), CW'(2));
        n = 0;
        for (int i = 0; i < 8; i++) begin cyc(0, 0, 0, 0, gc); n += int'(frame_start); end
        chk("coalesce_starts", CW'(n), CW'(1));
        chk("coalesce_snap", CW'(snap_table), CW'(gc));
        // force refresh in first hold-off cycle skips the gap
        cyc(0, 0, 0, 1, gc);
        cyc(0, 0, 1, 0, gc);
        chk("force_idle", CW'(busy), CW'(0));
        idle(2, gc);
        chk("force_start", CW'(frame_start), CW'(1));
        // frame_done on the timeout cycle counts as a normal completion
        idle(20, gc);
        cyc(0, 0, 0, 1, gc);
        chk("coincide_err", CW'(timeout_err), CW'(0));
        chk("coincide_cnt", CW'(frame_cnt), CW'(4));
        idle(5, gc);
        // update during SNAP keeps pending alive
        cyc(0, 1, 0, 0, ga); cyc(0, 1, 0, 0, ga);
        chk("snap_upd_pending", CW'(pending), CW'(1));
        idle(1, ga);
        cyc(0, 0, 0, 1, ga);
        n = 0;
        for (int i = 0; i < 8; i++) begin cyc(0, 0, 0, 0, ga); n += int'(frame_start); end
        chk("snap_upd_second", CW'(n), CW'(1));
        // timeout: withhold frame_done
        idle(30, ga);
        chk("timeout_err", CW'(timeout_err), CW'(1));
        chk("timeout_cnt", CW'(frame_cnt), CW'(5));
        cyc(0, 0, 0, 1, ga);
        chk("late_done", CW'(frame_cnt), CW'(5));
        idle(5, ga);
        chk("err_sticky", CW'(timeout_err), CW'(1));
        cyc(1, 0, 0, 0, ga);
        chk("err_rst", CW'({timeout_err, pending}), CW'(2'b01));
        for (int i = 0; i < 3000; i++) begin
            rg = {$urandom, $urandom, $urandom, $urandom};
            cyc($urandom_range(199) == 0, $urandom_range(19) == 0, $urandom_range(49) == 0,
                $urandom_range(9) == 0, rg);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lcd_refresh_scheduler.md
Name: lcd_refresh_scheduler

Overview:
- Sequences LCD frame refreshes for the game display.
- Watches the live game table and update strobes from the game controller, then captures a stable snapshot for the RAM-to-LCD conversion path.
- Issues one start pulse per frame, waits for the frame-done strobe and enforces a minimum hold-off between frames.
- Coalesces bursts of table updates into a single refresh and recovers from a stalled LCD path with a timeout.

Parameters:
- TABLE_W, 100, width of game table bitmap.
- MIN_GAP, 1000, hold-off cycles after a frame completes (legal range >=1).
- GAP_W, 16, width of hold-off counter (2^GAP_W > MIN_GAP).
- TIMEOUT, 50000, max cycles in WAIT_DONE before abandoning frame (legal range >=2).
- TO_W, 16, width of timeout counter (2^TO_W > TIMEOUT).

Ports:
- clk, in, 1: system clock; all logic on rising edge.
- rst, in, 1: reset, synchronous, active-high.
- game_table, in, TABLE_W: live game table from game controller.
- table_upd, in, 1: one-cycle strobe, game table changed.
- force_refresh, in, 1: one-cycle strobe, refresh now and skip hold-off.
- frame_done, in, 1: one-cycle strobe from LCD path, last byte of frame written.
- frame_start, out, 1: one-cycle pulse to RAM/LCD path, begin frame.
- snap_table, out, TABLE_W: registered snapshot that drives the RAM converter.
- busy, out, 1: high when state != IDLE.
- pending, out, 1: a refresh request is outstanding.
- frame_cnt, out, 8: count of completed frames, wraps 255->0.
- timeout_err, out, 1: sticky, at least one frame was abandoned.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; snap_table=0; frame_start=0; frame_cnt=0; timeout_err=0; counters=0.
  - pending=1, so a power-up frame is always drawn.
  - busy=0.
- Request term: req = pending | table_upd | force_refresh.
- pending update:
  - Set on any cycle where table_upd or force_refresh=1.
  - Cleared on the edge that leaves SNAP, unless table_upd or force_refresh=1 in that same SNAP cycle; set wins.
- FSM states: IDLE, SNAP, START, WAIT_DONE, HOLDOFF.
- IDLE: req=1 -> SNAP next cycle; otherwise stay.
- SNAP (1 cycle):
  - snap_table <= game_table on exiting edge; go to START.
  - snap_table changes only here, never during a frame.
- START (1 cycle):
  - frame_start=1 during this cycle only; go to WAIT_DONE.
  - Timeout counter cleared.
- WAIT_DONE:
  - Timeout counter increments every cycle.
  - frame_done=1 -> HOLDOFF; frame_cnt+1 (mod 256); gap counter cleared.
  - Else if counter==TIMEOUT-1 -> HOLDOFF; timeout_err<=1; frame_cnt unchanged.
  - If frame_done and timeout coincide, frame_done wins: normal completion, no error.
- HOLDOFF:
  - Gap counter increments each cycle; counter==MIN_GAP-1 -> IDLE.
  - force_refresh=1 in HOLDOFF -> IDLE next cycle, sets pending.
- Strobes outside their consuming state:
  - frame_done outside WAIT_DONE is ignored.
  - table_upd or force_refresh in any non-IDLE state only sets pending; no state change except the HOLDOFF rule above.
- Coalescing: any number of updates during one frame+hold-off produce exactly one following frame.
- Latency: table_upd in IDLE at cycle n -> SNAP at n+1 -> frame_start high at n+2.
- frame_start is never asserted twice without an intervening WAIT_DONE exit.
- timeout_err clears only on rst.
- Reset mid-frame returns to IDLE with pending=1; a new frame starts 2 cycles after rst falls.

Test Plan:
- Power-up: MIN_GAP=4, rst 3 cycles then low -> frame_start at 2nd cycle after release; snap_table = game_table sampled in SNAP; busy=1 until HOLDOFF ends.
- Single update: idle, table_upd at n, game_table=100'h5 -> frame_start at n+2, snap_table=100'h5; frame_done 10 cycles later -> frame_cnt=1, IDLE after 4 hold-off cycles.
- Coalescing: three table_upd strobes during WAIT_DONE, game_table changes each time -> exactly one further frame_start, issued 2 cycles after HOLDOFF exit; snap_table holds the last value; frame_cnt=2 after both frames.
- Force skip: force_refresh during HOLDOFF cycle 1 with MIN_GAP=1000 -> IDLE next cycle, frame_start 2 cycles later, not 1000.
- Timeout: TIMEOUT=20, withhold frame_done -> 20 cycles after frame_start enters HOLDOFF; timeout_err=1; frame_cnt unchanged; late frame_done ignored; err persists until rst.
- Edge cases: frame_done on the same cycle as timeout -> frame_cnt increments, timeout_err stays 0; table_upd in SNAP cycle -> pending=1 after SNAP, second frame follows hold-off.
